// File: rtl/uart_prog_loader_ctrl.sv
// UART program loader: ASCII hex to imem words, CPU run/stop commands,
// per-byte response echo and CPU-halt notification on a shared TX.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting; a pending halt notice wins over a new RX byte
// DECODE    | classify the latched byte, update shift/nib_cnt/run
// WRITE     | one-cycle imem write of the assembled word
// RESP_WAIT | hold the response until the transmitter is free
// TX_GAP    | two-cycle settle so tx_busy can rise before next send
module uart_prog_loader_ctrl #(
    parameter int IMEM_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_rdy,
    output logic              rx_rdy_clr,
    output logic [7:0]        tx_data,
    output logic              tx_wr_en,
    input  logic              tx_busy,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_run,
    input  logic              cpu_halted,
    output logic              load_full,
    output logic              err_seen
);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WRITE,
        RESP_WAIT,
        TX_GAP
    } state_t;

    localparam logic [7:0] CH_G    = 8'h47;
    localparam logic [7:0] CH_X    = 8'h58;
    localparam logic [7:0] CH_Z    = 8'h5A;
    localparam logic [7:0] CH_H    = 8'h48;
    localparam logic [7:0] CH_QM   = 8'h3F;
    localparam logic [7:0] CH_BANG = 8'h21;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_SP   = 8'h20;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

    state_t              state_q, state_d;
    logic [7:0]          byte_q, byte_d;
    logic [31:0]         shift_q, shift_d;
    logic [2:0]          nib_cnt_q, nib_cnt_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [7:0]          resp_q, resp_d;
    logic [1:0]          gap_cnt_q, gap_cnt_d;
    logic                halt_pend_q, halt_pend_d;
    logic                halted_q;
    logic                cpu_run_q, cpu_run_d;
    logic                load_full_q, load_full_d;
    logic                err_seen_q, err_seen_d;
    logic                rx_rdy_clr_q, rx_rdy_clr_d;
    logic                tx_wr_en_q, tx_wr_en_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_waddr_q, imem_waddr_d;
    logic [31:0]         imem_wdata_q, imem_wdata_d;

    logic                is_hex;
    logic [3:0]          nib;
    logic                halt_rise;
    logic [31:0]         shift_next;

    assign halt_rise  = cpu_halted & ~halted_q & cpu_run_q;
    assign shift_next = {shift_q[27:0], nib};

    always_comb begin
        is_hex = 1'b1;
        nib    = 4'd0;
        if (byte_q >= 8'h30 && byte_q <= 8'h39) begin
            nib = byte_q[3:0];
        end else if ((byte_q >= 8'h41 && byte_q <= 8'h46) ||
                     (byte_q >= 8'h61 && byte_q <= 8'h66)) begin
            nib = byte_q[3:0] + 4'd9;
        end else begin
            is_hex = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            byte_q       <= 8'd0;
            shift_q      <= 32'd0;
            nib_cnt_q    <= 3'd0;
            wr_ptr_q     <= '0;
            resp_q       <= 8'd0;
            gap_cnt_q    <= 2'd0;
            halt_pend_q  <= 1'b0;
            halted_q     <= 1'b0;
            cpu_run_q    <= 1'b0;
            load_full_q  <= 1'b0;
            err_seen_q   <= 1'b0;
            rx_rdy_clr_q <= 1'b0;
            tx_wr_en_q   <= 1'b0;
            tx_data_q    <= 8'd0;
            imem_we_q    <= 1'b0;
            imem_waddr_q <= '0;
            imem_wdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            shift_q      <= shift_d;
            nib_cnt_q    <= nib_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            resp_q       <= resp_d;
            gap_cnt_q    <= gap_cnt_d;
            halt_pend_q  <= halt_pend_d;
            halted_q     <= cpu_halted;
            cpu_run_q    <= cpu_run_d;
            load_full_q  <= load_full_d;
            err_seen_q   <= err_seen_d;
            rx_rdy_clr_q <= rx_rdy_clr_d;
            tx_wr_en_q   <= tx_wr_en_d;
            tx_data_q    <= tx_data_d;
            imem_we_q    <= imem_we_d;
            imem_waddr_q <= imem_waddr_d;
            imem_wdata_q <= imem_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        shift_d      = shift_q;
        nib_cnt_d    = nib_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        resp_d       = resp_q;
        gap_cnt_d    = gap_cnt_q;
        // a new edge is kept even in the cycle the previous one is serviced
        halt_pend_d  = halt_pend_q | halt_rise;
        cpu_run_d    = cpu_run_q;
        load_full_d  = load_full_q;
        err_seen_d   = err_seen_q;
        rx_rdy_clr_d = 1'b0;
        tx_wr_en_d   = 1'b0;
        tx_data_d    = tx_data_q;
        imem_we_d    = 1'b0;
        imem_waddr_d = imem_waddr_q;
        imem_wdata_d = imem_wdata_q;

        case (state_q)
            IDLE: begin
                if (halt_pend_q) begin
                    resp_d      = CH_H;
                    halt_pend_d = halt_rise;
                    state_d     = RESP_WAIT;
                end else if (rx_rdy) begin
                    byte_d       = rx_data;
                    rx_rdy_clr_d = 1'b1;
                    state_d      = DECODE;
                end
            end

            DECODE: begin
                state_d = RESP_WAIT;
                resp_d  = byte_q;
                if (is_hex) begin
                    if (cpu_run_q || load_full_q) begin
                        resp_d     = CH_BANG;
                        err_seen_d = 1'b1;
                    end else begin
                        shift_d   = shift_next;
                        nib_cnt_d = nib_cnt_q + 3'd1;
                        if (nib_cnt_q == 3'd7) begin
                            // word address/data are presented during WRITE
                            state_d      = WRITE;
                            imem_we_d    = 1'b1;
                            imem_waddr_d = wr_ptr_q;
                            imem_wdata_d = shift_next;
                        end
                    end
                end else begin
                    case (byte_q)
                        CH_G: begin
                            cpu_run_d = 1'b1;
                            nib_cnt_d = 3'd0;
                        end
                        CH_X: begin
                            cpu_run_d = 1'b0;
                            nib_cnt_d = 3'd0;
                        end
                        CH_Z: begin
                            if (cpu_run_q) begin
                                resp_d     = CH_BANG;
                                err_seen_d = 1'b1;
                            end else begin
                                wr_ptr_d    = '0;
                                load_full_d = 1'b0;
                                nib_cnt_d   = 3'd0;
                            end
                        end
                        CH_CR, CH_LF, CH_SP: begin
                            state_d = IDLE;
                        end
                        default: begin
                            nib_cnt_d  = 3'd0;
                            resp_d     = CH_QM;
                            err_seen_d = 1'b1;
                        end
                    endcase
                end
            end

            WRITE: begin
                nib_cnt_d = 3'd0;
                if (wr_ptr_q == LAST_ADDR) begin
                    load_full_d = 1'b1;
                end else begin
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                end
                resp_d  = byte_q;
                state_d = RESP_WAIT;
            end

            RESP_WAIT: begin
                if (!tx_busy) begin
                    tx_wr_en_d = 1'b1;
                    tx_data_d  = resp_q;
                    gap_cnt_d  = 2'd1;
                    state_d    = TX_GAP;
                end
            end

            TX_GAP: begin
                if (gap_cnt_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 2'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_rdy_clr = rx_rdy_clr_q;
    assign tx_data    = tx_data_q;
    assign tx_wr_en   = tx_wr_en_q;
    assign imem_we    = imem_we_q;
    assign imem_waddr = imem_waddr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_run    = cpu_run_q;
    assign load_full  = load_full_q;
    assign err_seen   = err_seen_q;

endmodule
